hypercpu_mem_arbiter: RTL and testbench

HYPERCPU_MEM_ARBITER -- requirements
Module: hypercpu_mem_arbiter

---
 rtl/hypercpu_mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_hypercpu_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hypercpu_mem_arbiter.sv
// Purpose : arbitrates a fetch and a data requester onto one shared memory bus with region decode and per-region waits.
// Latency : zero-wait access acks two cycles after the request is sampled in IDLE; each wait cycle adds one.
// Backpr. : requesters hold req/addr/data until their one-cycle ack; a new grant is only made from IDLE.
//
// Ports:
//   clk, reset_n                 - single clock, async active-low reset
//   if_req/if_addr/if_ack        - fetch requester (reads only)
//   d_req/d_we/d_addr/d_wdata/d_ack - data requester
//   rdata, err                   - registered result and error flag, valid with either ack
//   mem_addr/mem_read/mem_write  - shared bus address and data
//   mem_read_enabled/mem_write_enabled/sel - bus strobes and one-hot region select
//
// Build option: define HYPERCPU_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise the data requester always wins a simultaneous request.
module hypercpu_mem_arbiter #(
  parameter int unsigned RAM_WAIT = 1,
  parameter int unsigned IO_WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_read,
  output logic [31:0] mem_write,
  output logic        mem_read_enabled,
  output logic        mem_write_enabled,
  output logic [3:0]  sel
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] LP_RAM_WAIT = 4'(RAM_WAIT);
  localparam logic [3:0] LP_IO_WAIT  = 4'(IO_WAIT);

  // One-hot region from the top address byte; zero means unmapped.
  function automatic logic [3:0] f_decode(input logic [31:0] a);
    logic [3:0] s;
    s = 4'b0000;
    case (a[31:24])
      8'h00:   s = 4'b0001;
      8'h01:   s = 4'b0010;
      8'h90:   s = 4'b0100;
      8'hA0:   s = 4'b1000;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  state_t      r_state;
  state_t      w_next;

  logic        r_gnt_d;
  logic [31:0] r_addr;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [3:0]  r_sel;
  logic        r_acc_err;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_any_req;
  logic        w_gnt_d;
  logic [31:0] w_addr;
  logic        w_we;
  logic [31:0] w_wdata;
  logic [3:0]  w_sel_dec;
  logic        w_acc_err;
  logic [3:0]  w_wait;
  logic        w_in_access;

  assign w_any_req = if_req | d_req;

`ifdef HYPERCPU_ARB_ROUND_ROBIN_EN
  // Set when fetch was the last requester served; reset value favours data next.
  logic r_last_if;
  assign w_gnt_d = d_req & (~if_req | r_last_if);
`else
  assign w_gnt_d = d_req;
`endif

  assign w_addr    = w_gnt_d ? d_addr : if_addr;
  assign w_we      = w_gnt_d & d_we;
  assign w_wdata   = w_gnt_d ? d_wdata : 32'h0;
  assign w_sel_dec = f_decode(w_addr);
  // Writes into ROM are refused just like unmapped addresses.
  assign w_acc_err = (w_sel_dec == 4'b0000) | (w_we & w_sel_dec[0]);

  always_comb begin
    w_wait = 4'd0;
    if (!w_acc_err) begin
      if (w_sel_dec[1])
        w_wait = LP_RAM_WAIT;
      else if (w_sel_dec[2] | w_sel_dec[3])
        w_wait = LP_IO_WAIT;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_next = S_ACCESS;
      S_ACCESS: if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Request latch, wait counter and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt_d   <= 1'b0;
      r_addr    <= 32'h0;
      r_we      <= 1'b0;
      r_wdata   <= 32'h0;
      r_sel     <= 4'b0000;
      r_acc_err <= 1'b0;
      r_cnt     <= 4'd0;
      r_rdata   <= 32'h0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt_d   <= w_gnt_d;
            r_addr    <= w_addr;
            r_we      <= w_we;
            r_wdata   <= w_wdata;
            r_sel     <= w_acc_err ? 4'b0000 : w_sel_dec;
            r_acc_err <= w_acc_err;
            r_cnt     <= w_wait;
          end
        end
        S_ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_err <= r_acc_err;
            if (r_acc_err)
              r_rdata <= 32'h0;
            else if (!r_we)
              r_rdata <= mem_read;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HYPERCPU_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_last_if <= 1'b1;
    else if ((r_state == S_IDLE) && w_any_req)
      r_last_if <= ~w_gnt_d;
  end
`endif

  // Bus outputs are only live during ACCESS; a refused access drives no strobe.
  assign w_in_access       = (r_state == S_ACCESS);
  assign mem_addr          = w_in_access ? r_addr : 32'h0;
  assign sel               = w_in_access ? r_sel : 4'b0000;
  assign mem_read_enabled  = w_in_access & ~r_acc_err & ~r_we;
  assign mem_write_enabled = w_in_access & ~r_acc_err & r_we;
  assign mem_write         = mem_write_enabled ? r_wdata : 32'h0;

  assign if_ack = (r_state == S_RESP) & ~r_gnt_d;
  assign d_ack  = (r_state == S_RESP) & r_gnt_d;
  assign rdata  = r_rdata;
  assign err    = r_err;

endmodule

// File: tb/tb_hypercpu_mem_arbiter.sv
// Purpose : directed self-checking bench for hypercpu_mem_arbiter (RAM_WAIT=3, IO_WAIT=2).
// Latency : measures request-to-ack cycles and strobe lengths per transaction.
// Backpr. : requesters hold req until ack, then drop it for at least one IDLE cycle.
module tb_hypercpu_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] mem_addr;
  logic [31:0] mem_read;
  logic [31:0] mem_write;
  logic        mem_read_enabled;
  logic        mem_write_enabled;
  logic [3:0]  sel;

  int n_checks;
  int n_fail;

  hypercpu_mem_arbiter #(.RAM_WAIT(3), .IO_WAIT(2)) u_dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .if_req            (if_req),
    .if_addr           (if_addr),
    .if_ack            (if_ack),
    .d_req             (d_req),
    .d_we              (d_we),
    .d_addr            (d_addr),
    .d_wdata           (d_wdata),
    .d_ack             (d_ack),
    .rdata             (rdata),
    .err               (err),
    .mem_addr          (mem_addr),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_read_enabled  (mem_read_enabled),
    .mem_write_enabled (mem_write_enabled),
    .sel               (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Results of the last transaction.
  int          t_lat;
  int          t_nrd;
  int          t_nwr;
  logic [3:0]  t_sel;
  logic [31:0] t_wd;
  logic        t_got_d;
  logic        t_ack_after;

  // One request from IDLE to ack; ends one cycle after the ack (back in IDLE).
  task automatic txn(input logic use_d, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd);
    logic done;
    @(negedge clk);
    if (use_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    t_lat = 0; t_nrd = 0; t_nwr = 0; t_sel = 4'b0; t_wd = 32'h0; t_got_d = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      t_lat++;
      if (mem_read_enabled) t_nrd++;
      if (mem_write_enabled) begin t_nwr++; t_wd = mem_write; end
      t_sel = t_sel | sel;
      if (if_ack || d_ack) begin
        done = 1'b1;
        t_got_d = d_ack;
      end
    end
    if (!done) chk("txn_timeout", 32'd0, 32'd1);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(posedge clk); #1;
    t_ack_after = if_ack | d_ack;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk(tag, {if_ack, d_ack, err, mem_read_enabled, mem_write_enabled, sel}, 32'h0);
    chk(tag, mem_addr, 32'h0);
    chk(tag, mem_write, 32'h0);
  endtask

  int          ack_cnt;
  int          ack_cyc[3];
  logic [2:0]  ack_who;
  logic [2:0]  exp_who;

  initial begin
    n_checks = 0; n_fail = 0;
    reset_n = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    mem_read = 32'hFFFF_FFFF;

    // Reset state.
    #12;
    chk_idle_outputs("reset_outputs");
    chk("reset_rdata", rdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // ROM fetch read, zero waits.
    mem_read = 32'h0100_0000;
    txn(1'b0, 1'b0, 32'h0000_0003, 32'h0);
    chk("rom_rd_lat", 32'(t_lat), 32'd2);
    chk("rom_rd_strobes", 32'(t_nrd), 32'd1);
    chk("rom_rd_sel", {28'h0, t_sel}, 32'h1);
    chk("rom_rd_who", {31'h0, t_got_d}, 32'h0);
    chk("rom_rd_data", rdata, 32'h0100_0000);
    chk("rom_rd_err", {31'h0, err}, 32'h0);
    chk("ack_one_cycle", {31'h0, t_ack_after}, 32'h0);
    chk_idle_outputs("idle_after_ack");

    // RAM write, 3 waits: strobe 4 cycles, rdata untouched.
    txn(1'b1, 1'b1, 32'h0100_0010, 32'hDEAD_BEEF);
    chk("ram_wr_lat", 32'(t_lat), 32'd5);
    chk("ram_wr_strobes", 32'(t_nwr), 32'd4);
    chk("ram_wr_rd_strobes", 32'(t_nrd), 32'd0);
    chk("ram_wr_data", t_wd, 32'hDEAD_BEEF);
    chk("ram_wr_sel", {28'h0, t_sel}, 32'h2);
    chk("ram_wr_rdata_kept", rdata, 32'h0100_0000);
    chk("ram_wr_err", {31'h0, err}, 32'h0);

    // RAM read.
    mem_read = 32'hCAFE_F00D;
    txn(1'b1, 1'b0, 32'h0100_0020, 32'h0);
    chk("ram_rd_lat", 32'(t_lat), 32'd5);
    chk("ram_rd_strobes", 32'(t_nrd), 32'd4);
    chk("ram_rd_data", rdata, 32'hCAFE_F00D);

    // Display write, IO_WAIT=2.
    txn(1'b1, 1'b1, 32'hA000_0001, 32'h0000_0012);
    chk("disp_wr_lat", 32'(t_lat), 32'd4);
    chk("disp_wr_strobes", 32'(t_nwr), 32'd3);
    chk("disp_wr_sel", {28'h0, t_sel}, 32'h8);
    chk("disp_wr_data", t_wd, 32'h0000_0012);
    chk("disp_wr_rdata_kept", rdata, 32'hCAFE_F00D);

    // Input read from the fetch side.
    mem_read = 32'h0000_55AA;
    txn(1'b0, 1'b0, 32'h9000_0004, 32'h0);
    chk("inp_rd_lat", 32'(t_lat), 32'd4);
    chk("inp_rd_strobes", 32'(t_nrd), 32'd3);
    chk("inp_rd_sel", {28'h0, t_sel}, 32'h4);
    chk("inp_rd_data", rdata, 32'h0000_55AA);

    // Unmapped read.
    txn(1'b1, 1'b0, 32'h5500_0000, 32'h0);
    chk("unmap_lat", 32'(t_lat), 32'd2);
    chk("unmap_strobes", 32'(t_nrd + t_nwr), 32'd0);
    chk("unmap_sel", {28'h0, t_sel}, 32'h0);
    chk("unmap_who", {31'h0, t_got_d}, 32'h1);
    chk("unmap_err", {31'h0, err}, 32'h1);
    chk("unmap_rdata", rdata, 32'h0);

    // Successful read clears err.
    mem_read = 32'h0000_0077;
    txn(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    chk("ok_err_clear", {31'h0, err}, 32'h0);
    chk("ok_rdata", rdata, 32'h0000_0077);

    // Write to ROM is refused.
    txn(1'b1, 1'b1, 32'h0000_0005, 32'h0000_1111);
    chk("romwr_lat", 32'(t_lat), 32'd2);
    chk("romwr_strobes", 32'(t_nrd + t_nwr), 32'd0);
    chk("romwr_err", {31'h0, err}, 32'h1);
    chk("romwr_rdata", rdata, 32'h0);

    // Restore a non-zero rdata so the reset clear is visible.
    txn(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    chk("pre_rst_rdata", rdata, 32'h0000_0077);

    // Reset in the middle of a RAM read.
    @(negedge clk);
    mem_read = 32'h0000_1234;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0100_0020;
    @(posedge clk); #1;
    chk("midrst_strobe_on", {31'h0, mem_read_enabled}, 32'h1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("midrst_outputs");
    chk("midrst_rdata", rdata, 32'h0);
    @(negedge clk);
    d_req = 1'b0;
    reset_n = 1'b1;
    ack_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (if_ack || d_ack) ack_cnt++;
    end
    chk("midrst_no_ack", 32'(ack_cnt), 32'd0);
    mem_read = 32'h0BAD_CAFE;
    txn(1'b0, 1'b0, 32'h0000_0004, 32'h0);
    chk("post_rst_lat", 32'(t_lat), 32'd2);
    chk("post_rst_rdata", rdata, 32'h0BAD_CAFE);
    chk("post_rst_err", {31'h0, err}, 32'h0);

    // Simultaneous held requests: order of the first three grants.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0003;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0008;
    ack_cnt = 0; ack_who = 3'b000;
    for (int i = 0; i < 60 && ack_cnt < 3; i++) begin
      @(posedge clk); #1;
      if (if_ack || d_ack) begin
        ack_who[ack_cnt] = d_ack;
        ack_cyc[ack_cnt] = i;
        ack_cnt++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
`ifdef HYPERCPU_ARB_ROUND_ROBIN_EN
    exp_who = 3'b101;
`else
    exp_who = 3'b111;
`endif
    chk("arb_ack_count", 32'(ack_cnt), 32'd3);
    chk("arb_order", {29'h0, ack_who}, {29'h0, exp_who});
    if (ack_cnt == 3) begin
      chk("arb_gap01", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
      chk("arb_gap12", 32'(ack_cyc[2] - ack_cyc[1]), 32'd3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
